// File: rtl/mfp_seven_segment_pkg.sv
// Shared seven-segment definitions: segment bit order, hex glyph table and the all-off pattern.
// Segment vectors are active low, ordered {g,f,e,d,c,b,a} with segment a in bit 0.
package mfp_seven_segment_pkg;

  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Standard DE-board glyphs for hex digits 0..F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/mfp_hex_to_segments.sv
// Combinational hex digit to active-low seven-segment decoder.
module mfp_hex_to_segments
  import mfp_seven_segment_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = GLYPH[hex];

endmodule

// File: rtl/mfp_multi_digit_seven_segment_ctrl.sv
// N-digit seven-segment controller: shadowed value, leading-zero blanking, blink,
// static per-digit outputs and a guarded time-multiplexed scan output.
module mfp_multi_digit_seven_segment_ctrl
  import mfp_seven_segment_pkg::*;
#(
  parameter int N_DIGITS      = 8,
  parameter int SCAN_DIV      = 50000,
  parameter int GUARD         = 1,
  parameter int BLINK_DIV     = 12500000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   number,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blink_mask,
  input  logic                    blank_lz,
  output logic [7*N_DIGITS-1:0]   seg_static,
  output logic [N_DIGITS-1:0]     dp_static,
  output logic [6:0]              seg_mux,
  output logic                    dp_mux,
  output logic [N_DIGITS-1:0]     an
);

  localparam int SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W   = (N_DIGITS > 1)  ? $clog2(N_DIGITS)  : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [SCAN_W:0]    GUARD_END  = (SCAN_W + 1)'(GUARD);
  localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [4*N_DIGITS-1:0] number_reg;
  logic [N_DIGITS-1:0]   dp_reg;
  logic [N_DIGITS-1:0]   mask_reg;
  logic                  blank_lz_reg;

  logic [SCAN_W-1:0]     slot_cnt_reg;
  logic [IDX_W-1:0]      scan_idx_reg;
  logic [BLINK_W-1:0]    blink_cnt_reg;
  logic                  blink_phase_reg;

  logic [7*N_DIGITS-1:0] seg_static_reg;
  logic [N_DIGITS-1:0]   dp_static_reg;
  logic [6:0]            seg_mux_reg;
  logic                  dp_mux_reg;
  logic [N_DIGITS-1:0]   an_reg;

  logic [3:0]            digit_val [N_DIGITS];
  logic [6:0]            digit_glyph [N_DIGITS];
  logic [N_DIGITS-1:0]   blanked;
  logic [N_DIGITS-1:0]   digit_off;
  logic [N_DIGITS-1:0]   an_onehot;
  logic [7*N_DIGITS-1:0] seg_static_next;
  logic [N_DIGITS-1:0]   dp_static_next;

  logic                  slot_last;
  logic                  blink_last;
  logic                  in_guard;
  logic                  lz_run;
  logic [3:0]            mux_val;
  logic [6:0]            mux_glyph;
  logic                  mux_off;
  logic                  mux_dp_req;

  // Tear-free capture: the display only ever sees a complete, coherent value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number_reg   <= '0;
      dp_reg       <= '0;
      mask_reg     <= '0;
      blank_lz_reg <= 1'b0;
    end else if (load) begin
      number_reg   <= number;
      dp_reg       <= dp_in;
      mask_reg     <= blink_mask;
      blank_lz_reg <= blank_lz;
    end
  end

  assign slot_last  = (slot_cnt_reg == SCAN_LAST);
  assign blink_last = (blink_cnt_reg == BLINK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_reg    <= '0;
      scan_idx_reg    <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      if (slot_last) begin
        slot_cnt_reg <= '0;
        scan_idx_reg <= (scan_idx_reg == IDX_LAST) ? '0 : scan_idx_reg + IDX_W'(1);
      end else begin
        slot_cnt_reg <= slot_cnt_reg + SCAN_W'(1);
      end
      if (blink_last) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
      end
    end
  end

  // Blank chain walks down from the top digit; digit 0 is never blanked
  always_comb begin
    blanked = '0;
    lz_run  = blank_lz_reg;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      lz_run     = lz_run && (number_reg[4*i +: 4] == 4'h0) && !dp_reg[i];
      blanked[i] = lz_run;
    end
  end

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign digit_val[gi] = number_reg[4*gi +: 4];

    mfp_hex_to_segments u_dec (
      .hex (digit_val[gi]),
      .seg (digit_glyph[gi])
    );

    assign digit_off[gi]              = blanked[gi] || (blink_phase_reg && mask_reg[gi]);
    assign seg_static_next[7*gi +: 7] = digit_off[gi] ? SEG_OFF : digit_glyph[gi];
    assign dp_static_next[gi]         = digit_off[gi] || !dp_reg[gi];
    assign an_onehot[gi]              = (scan_idx_reg == IDX_W'(gi));
  end

  always_comb begin
    mux_val    = 4'h0;
    mux_off    = 1'b0;
    mux_dp_req = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scan_idx_reg == IDX_W'(i)) begin
        mux_val    = number_reg[4*i +: 4];
        mux_off    = digit_off[i];
        mux_dp_req = dp_reg[i];
      end
    end
  end

  mfp_hex_to_segments u_mux_dec (
    .hex (mux_val),
    .seg (mux_glyph)
  );

  // Guard cycles at the start of each slot keep the previous digit from ghosting
  assign in_guard = ({1'b0, slot_cnt_reg} < GUARD_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_static_reg <= {N_DIGITS{SEG_OFF}};
      dp_static_reg  <= '1;
      seg_mux_reg    <= SEG_OFF;
      dp_mux_reg     <= 1'b1;
      an_reg         <= AN_OFF;
    end else begin
      seg_static_reg <= seg_static_next;
      dp_static_reg  <= dp_static_next;
      if (in_guard) begin
        seg_mux_reg <= SEG_OFF;
        dp_mux_reg  <= 1'b1;
        an_reg      <= AN_OFF;
      end else begin
        seg_mux_reg <= mux_off ? SEG_OFF : mux_glyph;
        dp_mux_reg  <= mux_off || !mux_dp_req;
        an_reg      <= AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
      end
    end
  end

  assign seg_static = seg_static_reg;
  assign dp_static  = dp_static_reg;
  assign seg_mux    = seg_mux_reg;
  assign dp_mux     = dp_mux_reg;
  assign an         = an_reg;

endmodule
